// File: rtl/mmio_fabric.sv
// mmio_fabric: address-decoded MMIO interconnect for the picorv32 native bus.
// One CPU request is latched, routed to the slave whose base byte matches
// mem_addr[31:24], and completed with a registered one-cycle mem_ready.
// Unmapped accesses and slaves that never answer complete with ERR_RDATA and
// are logged in err_addr / err_count.
module mmio_fabric #(
    parameter int unsigned                NUM_SLAVES     = 4,
    parameter logic [NUM_SLAVES*8-1:0]    SLAVE_BASE     = {8'h04, 8'h03, 8'h05, 8'h06},
    parameter int unsigned                TIMEOUT_CYCLES = 255,
    parameter logic [31:0]                ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       mem_valid,
    input  logic [31:0]                mem_addr,
    input  logic [31:0]                mem_wdata,
    input  logic [3:0]                 mem_wstrb,
    output logic                       mem_ready,
    output logic [31:0]                mem_rdata,
    output logic [NUM_SLAVES-1:0]      s_valid,
    output logic [31:0]                s_addr,
    output logic [31:0]                s_wdata,
    output logic [3:0]                 s_wstrb,
    input  logic [NUM_SLAVES-1:0]      s_ready,
    input  logic [NUM_SLAVES*32-1:0]   s_rdata,
    output logic                       err_pulse,
    output logic [31:0]                err_addr,
    output logic [7:0]                 err_count
);

    localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    // Counter only needs to reach TIMEOUT_CYCLES-1: the last permitted cycle
    // is detected by comparison rather than by counting past it.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_flag_q, err_flag_d;
    logic [31:0]         err_addr_q, err_addr_d;
    logic [7:0]          err_count_q, err_count_d;

    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic                ready_sel;
    logic [31:0]         rdata_sel;

    // Address decode: first (lowest-index) matching slot wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!hit && (mem_addr[31:24] == SLAVE_BASE[8*i +: 8])) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Select ready/read data of the slave currently being accessed.
    always_comb begin
        ready_sel = 1'b0;
        rdata_sel = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (IDX_W'(i) == idx_q) begin
                ready_sel = s_ready[i];
                rdata_sel = s_rdata[32*i +: 32];
            end
        end
    end

    // Next-state logic for the access FSM and its datapath registers.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rdata_d     = rdata_q;
        err_flag_d  = err_flag_q;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;

        case (state_q)
            ST_IDLE: begin
                err_flag_d = 1'b0;
                if (mem_valid) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    if (hit) begin
                        idx_d   = hit_idx;
                        cnt_d   = '0;
                        state_d = ST_ACCESS;
                    end else begin
                        rdata_d    = ERR_RDATA;
                        err_flag_d = 1'b1;
                        state_d    = ST_RESP;
                    end
                end
            end

            ST_ACCESS: begin
                if (!mem_valid) begin
                    // CPU abandoned the request: quietly return to idle.
                    state_d = ST_IDLE;
                end else if (ready_sel) begin
                    rdata_d = rdata_sel;
                    state_d = ST_RESP;
                end else if ((TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST)) begin
                    rdata_d    = ERR_RDATA;
                    err_flag_d = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
                if (err_flag_q) begin
                    err_addr_d = addr_q;
                    if (err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            err_flag_q  <= 1'b0;
            err_addr_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
            err_flag_q  <= err_flag_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    // One-hot slave request, only while in ACCESS.
    always_comb begin
        s_valid = '0;
        if (state_q == ST_ACCESS) begin
            for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
                s_valid[i] = (IDX_W'(i) == idx_q);
            end
        end
    end

    assign mem_ready = (state_q == ST_RESP);
    assign err_pulse = (state_q == ST_RESP) && err_flag_q;
    assign mem_rdata = rdata_q;
    assign s_addr    = addr_q;
    assign s_wdata   = wdata_q;
    assign s_wstrb   = wstrb_q;
    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_mmio_fabric.sv
// Self-checking bench for mmio_fabric: table of CPU accesses with a
// scoreboard of expected completions, plus hand-written priority,
// saturation and mid-access reset sequences.
module tb_mmio_fabric;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    always #5 clk = ~clk;

    logic         mem_valid = 1'b0;
    logic [31:0]  mem_addr = '0;
    logic [31:0]  mem_wdata = '0;
    logic [3:0]   mem_wstrb = '0;
    logic         mem_ready;
    logic [31:0]  mem_rdata;
    logic [3:0]   s_valid;
    logic [31:0]  s_addr, s_wdata;
    logic [3:0]   s_wstrb;
    logic [3:0]   s_ready;
    logic [127:0] s_rdata;
    logic         err_pulse;
    logic [31:0]  err_addr;
    logic [7:0]   err_count;

    // second instance with overlapping bases (slots 0 and 2 both 8'h04)
    logic         p_valid = 1'b0;
    logic         p_ready;
    logic [31:0]  p_rdata;
    logic [3:0]   p_s_valid;
    logic [31:0]  p_s_addr, p_s_wdata;
    logic [3:0]   p_s_wstrb;
    logic [3:0]   p_s_ready;
    logic [127:0] p_s_rdata;
    logic         p_err_pulse;
    logic [31:0]  p_err_addr;
    logic [7:0]   p_err_count;

    assign p_s_ready = p_s_valid;
    assign p_s_rdata = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};

    // slot0=04 slot1=03 slot2=05 slot3=06
    mmio_fabric #(
        .NUM_SLAVES(4), .SLAVE_BASE(32'h0605_0304),
        .TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .resetn(resetn),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .err_pulse(err_pulse), .err_addr(err_addr), .err_count(err_count)
    );

    // slot0=04 slot1=03 slot2=04 slot3=06
    mmio_fabric #(
        .NUM_SLAVES(4), .SLAVE_BASE(32'h0604_0304),
        .TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEAD_BEEF)
    ) dut_p (
        .clk(clk), .resetn(resetn),
        .mem_valid(p_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(p_ready), .mem_rdata(p_rdata),
        .s_valid(p_s_valid), .s_addr(p_s_addr), .s_wdata(p_s_wdata), .s_wstrb(p_s_wstrb),
        .s_ready(p_s_ready), .s_rdata(p_s_rdata),
        .err_pulse(p_err_pulse), .err_addr(p_err_addr), .err_count(p_err_count)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // slave models: slot i answers after wait_cfg[i] cycles of s_valid
    int          wait_cfg [4];
    logic [31:0] rd_cfg [4];
    int          sv_cnt [4];
    logic [3:0]  noise = '0;

    always @(posedge clk or negedge resetn) begin
        for (int i = 0; i < 4; i++) begin
            if (!resetn)          sv_cnt[i] <= 0;
            else if (s_valid[i])  sv_cnt[i] <= sv_cnt[i] + 1;
            else                  sv_cnt[i] <= 0;
        end
    end

    always_comb begin
        s_ready = '0;
        s_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            s_ready[i] = (s_valid[i] && (sv_cnt[i] == wait_cfg[i])) || noise[i];
            s_rdata[32*i +: 32] = rd_cfg[i];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard
    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] eaddr;
        logic [7:0]  ecnt;
        int          issue_cyc;
        int          issue_sv;
        int          lat;
        int          svc;
    } exp_t;

    exp_t        sb_q [$];
    exp_t        mon_e;
    int          sv_seen = 0;
    logic [31:0] cur_addr = '0, cur_wdata = '0;
    logic [3:0]  cur_wstrb = '0;
    int          m_cnt = 0;
    logic [31:0] m_eaddr = '0;

    // completion monitor
    always @(negedge clk) begin
        if (resetn) begin
            if (s_valid != 4'b0000) begin
                sv_seen = sv_seen + 1;
                chk("s_valid_onehot", {31'b0, $onehot(s_valid)}, 32'd1);
                chk("s_addr", s_addr, cur_addr);
                chk("s_wdata", s_wdata, cur_wdata);
                chk("s_wstrb", {28'b0, s_wstrb}, {28'b0, cur_wstrb});
            end
            if (err_pulse && !mem_ready)
                chk("err_pulse_without_ready", {31'b0, mem_ready}, 32'd1);
            if (mem_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ready: got mem_ready=1 expected no completion pending");
                end else begin
                    mon_e = sb_q.pop_front();
                    chk({mon_e.name, ".rdata"}, mem_rdata, mon_e.rdata);
                    chk({mon_e.name, ".err_pulse"}, {31'b0, err_pulse}, {31'b0, mon_e.err});
                    chk({mon_e.name, ".latency"}, 32'(cyc - mon_e.issue_cyc), 32'(mon_e.lat));
                    chk({mon_e.name, ".svalid_cycles"}, 32'(sv_seen - mon_e.issue_sv), 32'(mon_e.svc));
                    chk({mon_e.name, ".err_count"}, {24'b0, err_count}, {24'b0, mon_e.ecnt});
                    chk({mon_e.name, ".err_addr"}, err_addr, mon_e.eaddr);
                end
            end
        end
    end

    task automatic access(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [31:0] exp_rdata,
                          input logic exp_err, input int lat, input int svc);
        exp_t e;
        int   n;
        @(negedge clk);
        e.name      = name;
        e.rdata     = exp_rdata;
        e.err       = exp_err;
        e.eaddr     = m_eaddr;
        e.ecnt      = 8'(m_cnt);
        e.issue_cyc = cyc;
        e.issue_sv  = sv_seen;
        e.lat       = lat;
        e.svc       = svc;
        sb_q.push_back(e);
        if (exp_err) begin
            if (m_cnt < 255) m_cnt++;
            m_eaddr = addr;
        end
        cur_addr  = addr;
        cur_wdata = wdata;
        cur_wstrb = wstrb;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        mem_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_ready && n < 40);
        if (!mem_ready) begin
            checks++;
            failures++;
            $display("FAIL %s.timeout: got no mem_ready in %0d cycles expected completion", name, n);
            sb_q.delete();
        end
        mem_valid = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          slot;
        int          wt;
        logic [3:0]  noise;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          lat;
        int          svc;
    } vec_t;

    function automatic vec_t mkv(string name, logic [31:0] addr, logic [31:0] wdata,
                                 logic [3:0] wstrb, int slot, int wt, logic [3:0] nz,
                                 logic [31:0] er, logic ee, int lat, int svc);
        vec_t v;
        v.name = name; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
        v.slot = slot; v.wt = wt; v.noise = nz; v.exp_rdata = er;
        v.exp_err = ee; v.lat = lat; v.svc = svc;
        return v;
    endfunction

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected $finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen0;
        rd_cfg[0] = 32'h1234_5678;
        rd_cfg[1] = 32'hCAFE_0001;
        rd_cfg[2] = 32'h5A5A_5A5A;
        rd_cfg[3] = 32'h0BAD_0003;
        for (int i = 0; i < 4; i++) wait_cfg[i] = 0;

        //        name               addr          wdata         wstrb    slot wt    noise    exp_rdata     err  lat svc
        vecs[0] = mkv("rd0_zero_wait",   32'h0400_0010, 32'h0,        4'b0000, 0,   0,    4'b0000, 32'h1234_5678, 0,  2, 1);
        vecs[1] = mkv("wr1_wait3",       32'h0300_0004, 32'hA5A5_0001, 4'b0011, 1,   3,    4'b0000, 32'hCAFE_0001, 0,  5, 4);
        vecs[2] = mkv("unmapped",        32'h0700_0000, 32'h0,        4'b0000, -1,  0,    4'b0000, 32'hDEAD_BEEF, 1,  1, 0);
        vecs[3] = mkv("timeout2",        32'h0500_0020, 32'h0,        4'b0000, 2,   1000, 4'b1011, 32'hDEAD_BEEF, 1,  9, 8);
        vecs[4] = mkv("ready_last2",     32'h0500_0024, 32'h0,        4'b0000, 2,   7,    4'b0000, 32'h5A5A_5A5A, 0,  9, 8);
        vecs[5] = mkv("wr3_wait1",       32'h0600_00FC, 32'h1122_3344, 4'b1111, 3,   1,    4'b0000, 32'h0BAD_0003, 0,  3, 2);
        vecs[6] = mkv("unmapped_ff",     32'hFF12_3456, 32'h0,        4'b0000, -1,  0,    4'b0000, 32'hDEAD_BEEF, 1,  1, 0);
        vecs[7] = mkv("rd0_wait2_noise", 32'h04AB_CDEF, 32'h0,        4'b0000, 0,   2,    4'b1110, 32'h1234_5678, 0,  4, 3);

        // reset state
        repeat (2) @(negedge clk);
        chk("rst.mem_ready", {31'b0, mem_ready}, 32'd0);
        chk("rst.mem_rdata", mem_rdata, 32'd0);
        chk("rst.s_valid", {28'b0, s_valid}, 32'd0);
        chk("rst.s_addr", s_addr, 32'd0);
        chk("rst.s_wdata", s_wdata, 32'd0);
        chk("rst.s_wstrb", {28'b0, s_wstrb}, 32'd0);
        chk("rst.err_pulse", {31'b0, err_pulse}, 32'd0);
        chk("rst.err_addr", err_addr, 32'd0);
        chk("rst.err_count", {24'b0, err_count}, 32'd0);
        resetn = 1'b1;

        // table-driven accesses
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].slot >= 0) wait_cfg[vecs[i].slot] = vecs[i].wt;
            noise = vecs[i].noise;
            access(vecs[i].name, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                   vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].lat, vecs[i].svc);
            noise = '0;
        end
        @(negedge clk);
        chk("table.err_count", {24'b0, err_count}, 32'd3);
        chk("table.err_addr", err_addr, 32'hFF12_3456);

        // overlapping bases: lowest slot must win
        @(negedge clk);
        mem_addr  = 32'h0400_0000;
        mem_wstrb = 4'b0000;
        p_valid   = 1'b1;
        n = 0;
        seen0 = 0;
        do begin
            @(negedge clk);
            n++;
            if (p_s_valid != 4'b0000) begin
                chk("prio.s_valid", {28'b0, p_s_valid}, 32'h1);
                seen0++;
            end
        end while (!p_ready && n < 20);
        chk("prio.ready", {31'b0, p_ready}, 32'd1);
        chk("prio.rdata", p_rdata, 32'hA0A0_0000);
        chk("prio.svalid_cycles", 32'(seen0), 32'd1);
        p_valid = 1'b0;

        // error counter saturation
        for (int i = 0; i < 300; i++)
            access("sat_unmapped", 32'h0800_0000 + 32'(i), 32'h0, 4'b0000,
                   32'hDEAD_BEEF, 1'b1, 1, 0);
        @(negedge clk);
        chk("sat.err_count", {24'b0, err_count}, 32'd255);
        chk("sat.err_addr", err_addr, 32'h0800_0000 + 32'd299);

        // reset in the middle of a slave wait
        @(negedge clk);
        wait_cfg[1] = 1000;
        cur_addr  = 32'h0300_0100;
        cur_wdata = 32'h0;
        cur_wstrb = 4'b0000;
        mem_addr  = 32'h0300_0100;
        mem_wdata = 32'h0;
        mem_wstrb = 4'b0000;
        mem_valid = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst.pre_s_valid", {28'b0, s_valid}, 32'h2);
        #2;
        resetn = 1'b0;
        #1;
        chk("midrst.s_valid", {28'b0, s_valid}, 32'd0);
        chk("midrst.mem_ready", {31'b0, mem_ready}, 32'd0);
        chk("midrst.err_count", {24'b0, err_count}, 32'd0);
        chk("midrst.s_addr", s_addr, 32'd0);
        mem_valid = 1'b0;
        m_cnt   = 0;
        m_eaddr = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        wait_cfg[1] = 0;
        access("post_reset_rd1", 32'h0300_0008, 32'h0, 4'b0000, 32'hCAFE_0001, 1'b0, 2, 1);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmio_fabric.md
Name: mmio_fabric

Overview:
- Parametrised memory-mapped I/O interconnect for the picorv32 native bus. It generalises the SoC top's hard-wired sel/ready/rdata mux into N decoded slave ports.
- Each slave is selected by the top address byte. Responses are registered, and unmapped accesses and slave timeouts complete with an error word instead of hanging the CPU.
- Sits between cpu mem_* and peripherals: the UART register block, data_proc, and future accelerators.

Parameters:
- NUM_SLAVES, 4, number of slave ports (1..16).
- SLAVE_BASE, {8'h04,8'h03,8'h05,8'h06}, packed NUM_SLAVES*8 bits. Slot i is SLAVE_BASE[8*i+7:8*i] and is compared against mem_addr[31:24].
- TIMEOUT_CYCLES, 255, maximum cycles s_valid may stay asserted without s_ready. 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on an unmapped access or a timeout.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset, asynchronous, active-low.
- mem_valid  in  1  CPU request valid.
- mem_addr  in  32  CPU address.
- mem_wdata  in  32  CPU write data.
- mem_wstrb  in  4  CPU byte strobes; 0 means read.
- mem_ready  out  1  one-cycle completion strobe.
- mem_rdata  out  32  registered read data.
- s_valid  out  NUM_SLAVES  one-hot slave request.
- s_addr  out  32  latched address, shared by all slaves.
- s_wdata  out  32  latched write data.
- s_wstrb  out  4  latched strobes.
- s_ready  in  NUM_SLAVES  per-slave acknowledge.
- s_rdata  in  NUM_SLAVES*32  per-slave read data; slot i is bits [32*i+31:32*i].
- err_pulse  out  1  high for one cycle alongside an error completion.
- err_addr  out  32  address of the most recent error.
- err_count  out  8  saturating error counter.

Behaviour:
- Reset values (asynchronous, while resetn=0): state=IDLE; mem_ready=0, mem_rdata=0, s_valid=0, s_addr/s_wdata/s_wstrb=0, err_pulse=0, err_addr=0, err_count=0, timeout counter=0. Reset mid-access aborts the transaction with no completion.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On mem_valid, latch addr/wdata/wstrb into s_*.
  - Decode mem_addr[31:24] against all slots. On multiple hits, the lowest index wins.
  - On a hit: store the index, clear the counter, go to ACCESS.
  - On a miss: mem_rdata<=ERR_RDATA, flag error, go to RESP.
- ACCESS:
  - s_valid[idx]=1; all other bits stay 0.
  - Each cycle with s_ready[idx]=1: mem_rdata<=s_rdata slot idx (captured for writes too), go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES>0): mem_rdata<=ERR_RDATA, flag error, go to RESP.
  - s_ready in the final permitted cycle wins over the timeout. s_ready on non-selected slots is ignored.
  - If mem_valid drops in ACCESS (protocol violation): go to IDLE, drop s_valid, no mem_ready.
- RESP:
  - mem_ready=1 for exactly one cycle, then IDLE.
  - If error flagged: err_pulse=1 in the same cycle, err_addr<=s_addr, err_count increments and saturates at 255.
  - mem_rdata holds its value until the next capture.
- Latency: a zero-wait slave gives mem_ready 2 cycles after mem_valid is first sampled. A slave with W wait cycles gives 2+W. An unmapped access gives 1 cycle. A timeout gives TIMEOUT_CYCLES+1 cycles.
- mem_valid high in IDLE immediately after RESP starts a new transaction; picorv32 drops valid after ready, so no back-to-back double issue is possible.
- s_valid is strictly one-hot or zero. Slaves must not see s_valid outside ACCESS.

Test Plan:
- Zero-wait read: slave0 ties s_ready=1 with rdata 32'h1234_5678; CPU reads 0x0400_0010 -> s_valid=4'b0001 for 1 cycle, mem_ready 2 cycles after valid, mem_rdata=32'h1234_5678, err_count=0.
- Wait-state write: slave1 asserts s_ready after 3 cycles; CPU writes 0x0300_0004, wdata 32'hA5A5_0001, wstrb 4'b0011 -> s_addr/s_wdata/s_wstrb match, mem_ready at cycle 5, no err_pulse.
- Unmapped access: read 0x0700_0000 -> mem_ready 1 cycle later, mem_rdata=32'hDEAD_BEEF, err_pulse=1, err_addr=32'h0700_0000, err_count=1, s_valid never asserted.
- Timeout (TIMEOUT_CYCLES=8): slave2 never ready -> s_valid[2] high for 8 cycles, then mem_ready with ERR_RDATA and err_pulse. Repeat with s_ready on the 8th cycle -> slave data returned, no error.
- Priority and saturation: SLAVE_BASE with slots 0 and 2 both 8'h04 -> only s_valid[0]. Issue 300 unmapped accesses -> err_count=255.
- Reset mid-ACCESS: drop resetn during a slave wait -> s_valid, mem_ready and err_count go to 0 immediately with no clock edge. After release, a new read completes normally.
